// File: rtl/anton_neopixel_stream_decoder_pkg.sv
// Shared types and defaults for the NeoPixel receive path.
package anton_neopixel_stream_decoder_pkg;

    // Receive FSM states.
    typedef enum logic [1:0] {
        RX_SYNC = 2'd0,
        RX_IDLE = 2'd1,
        RX_HIGH = 2'd2,
        RX_LOW  = 2'd3
    } rx_state_t;

    localparam int BUFFER_END_DEFAULT    = 255;
    localparam int RESET_DELAY_DEFAULT   = 500;
    localparam int BIT_THRESHOLD_DEFAULT = 4;
    localparam int MAX_HIGH_DEFAULT      = 7;
    localparam int PIXEL_BITS            = 24;
    localparam int SYNC_DEPTH            = 2;

    // Width of a pixel index; never narrower than one bit.
    function automatic int buffer_bits(input int buffer_end);
        return (buffer_end < 1) ? 1 : $clog2(buffer_end + 1);
    endfunction

endpackage

// File: rtl/anton_neopixel_stream_decoder_if.sv
// Control inputs and decoded-pixel outputs of the stream decoder.
interface anton_neopixel_stream_decoder_if #(
    parameter int BUFFER_BITS = 8
);
    logic                   i_enable;
    logic                   i_err_clear;
    logic                   i_stream_in;
    logic [23:0]            o_pixel_data;
    logic [BUFFER_BITS-1:0] o_pixel_index;
    logic                   o_pixel_valid;
    logic                   o_frame_done;
    logic [BUFFER_BITS:0]   o_frame_pixels;
    logic                   o_err_partial;
    logic                   o_err_long_high;
    logic                   o_err_overrun;

    modport master (
        output i_enable, i_err_clear, i_stream_in,
        input  o_pixel_data, o_pixel_index, o_pixel_valid, o_frame_done,
               o_frame_pixels, o_err_partial, o_err_long_high, o_err_overrun
    );

    modport slave (
        input  i_enable, i_err_clear, i_stream_in,
        output o_pixel_data, o_pixel_index, o_pixel_valid, o_frame_done,
               o_frame_pixels, o_err_partial, o_err_long_high, o_err_overrun
    );
endinterface

// File: rtl/anton_neopixel_rx_sync.sv
// Multi-flop synchroniser for the asynchronous data line; resets to 0.
module anton_neopixel_rx_sync #(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic [DEPTH-1:0] r_sync;

    // Shift the raw input through the synchroniser chain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_sync[DEPTH-1];
endmodule

// File: rtl/anton_neopixel_stream_decoder.sv
// NeoPixel receive decoder: classifies high pulses by width, assembles
// 24-bit pixels MSB first and detects the low gap that ends a frame.
module anton_neopixel_stream_decoder
    import anton_neopixel_stream_decoder_pkg::*;
#(
    parameter int BUFFER_END    = BUFFER_END_DEFAULT,
    parameter int RESET_DELAY   = RESET_DELAY_DEFAULT,
    parameter int BIT_THRESHOLD = BIT_THRESHOLD_DEFAULT,
    parameter int MAX_HIGH      = MAX_HIGH_DEFAULT
) (
    input logic                             i_clk7mhz,
    input logic                             i_rst,
    anton_neopixel_stream_decoder_if.slave  bus
);
    localparam int BUFFER_BITS = buffer_bits(BUFFER_END);
    // Pixel counter saturates one past the last buffer index.
    localparam logic [BUFFER_BITS:0] PIX_LIMIT = (BUFFER_BITS+1)'(BUFFER_END + 1);
    localparam logic [BUFFER_BITS:0] PIX_ONE   = (BUFFER_BITS+1)'(1);
    // Low count of the cycle that completes the reset gap.
    localparam logic [9:0] LOW_LAST  = 10'(RESET_DELAY - 1);
    localparam logic [3:0] HIGH_MAX  = 4'(MAX_HIGH);
    localparam logic [3:0] HIGH_SAT  = 4'(MAX_HIGH + 1);
    localparam logic [3:0] BIT_THR   = 4'(BIT_THRESHOLD);

    rx_state_t              r_state;
    logic [3:0]             r_high_cnt;
    logic [9:0]             r_low_cnt;
    logic [4:0]             r_bit_cnt;
    logic [23:0]            r_shift;
    logic [BUFFER_BITS:0]   r_pix_cnt;
    logic [23:0]            r_pixel_data;
    logic [BUFFER_BITS-1:0] r_pixel_index;
    logic                   r_pixel_valid;
    logic                   r_frame_done;
    logic [BUFFER_BITS:0]   r_frame_pixels;
    logic                   r_err_partial;
    logic                   r_err_long_high;
    logic                   r_err_overrun;

    logic                   w_s;
    logic                   w_bit;
    logic [23:0]            w_shift_next;
    logic [BUFFER_BITS:0]   w_pix_inc;

    anton_neopixel_rx_sync #(.DEPTH(SYNC_DEPTH)) u_sync (
        .i_clk (i_clk7mhz),
        .i_rst (i_rst),
        .i_d   (bus.i_stream_in),
        .o_q   (w_s)
    );

    assign w_bit        = (r_high_cnt >= BIT_THR);
    assign w_shift_next = {r_shift[22:0], w_bit};
    assign w_pix_inc    = (r_pix_cnt == PIX_LIMIT) ? r_pix_cnt : (r_pix_cnt + PIX_ONE);

    // Receive FSM with its counters, shift register, strobes and sticky errors.
    always_ff @(posedge i_clk7mhz or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= RX_SYNC;
            r_high_cnt      <= 4'd0;
            r_low_cnt       <= 10'd0;
            r_bit_cnt       <= 5'd0;
            r_shift         <= 24'd0;
            r_pix_cnt       <= '0;
            r_pixel_data    <= 24'd0;
            r_pixel_index   <= '0;
            r_pixel_valid   <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_pixels  <= '0;
            r_err_partial   <= 1'b0;
            r_err_long_high <= 1'b0;
            r_err_overrun   <= 1'b0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            // Clear first so that any set below in the same cycle wins.
            if (bus.i_err_clear) begin
                r_err_partial   <= 1'b0;
                r_err_long_high <= 1'b0;
                r_err_overrun   <= 1'b0;
            end else begin
                r_err_partial   <= r_err_partial;
            end

            if (!bus.i_enable) begin
                r_state    <= RX_SYNC;
                r_high_cnt <= 4'd0;
                r_low_cnt  <= 10'd0;
                r_bit_cnt  <= 5'd0;
                r_shift    <= 24'd0;
                r_pix_cnt  <= '0;
            end else begin
                case (r_state)
                    RX_SYNC: begin
                        if (w_s) begin
                            r_low_cnt <= 10'd0;
                        end else if (r_low_cnt == LOW_LAST) begin
                            r_low_cnt <= 10'd0;
                            r_state   <= RX_IDLE;
                        end else begin
                            r_low_cnt <= r_low_cnt + 10'd1;
                        end
                    end
                    RX_IDLE: begin
                        if (w_s) begin
                            r_high_cnt <= 4'd1;
                            r_state    <= RX_HIGH;
                        end else begin
                            r_high_cnt <= 4'd0;
                        end
                    end
                    RX_HIGH: begin
                        if (w_s) begin
                            if (r_high_cnt < HIGH_SAT) begin
                                r_high_cnt <= r_high_cnt + 4'd1;
                            end else begin
                                r_high_cnt <= r_high_cnt;
                            end
                        end else if (r_high_cnt > HIGH_MAX) begin
                            // Overlong pulse: framing is lost, resynchronise.
                            r_err_long_high <= 1'b1;
                            r_bit_cnt       <= 5'd0;
                            r_shift         <= 24'd0;
                            r_pix_cnt       <= '0;
                            r_low_cnt       <= 10'd0;
                            r_state         <= RX_SYNC;
                        end else begin
                            r_shift   <= w_shift_next;
                            r_low_cnt <= 10'd1;
                            r_state   <= RX_LOW;
                            if (r_bit_cnt == 5'd23) begin
                                r_bit_cnt <= 5'd0;
                                r_pix_cnt <= w_pix_inc;
                                if (r_pix_cnt == PIX_LIMIT) begin
                                    r_err_overrun <= 1'b1;
                                end else begin
                                    r_pixel_valid <= 1'b1;
                                    r_pixel_data  <= w_shift_next;
                                    r_pixel_index <= r_pix_cnt[BUFFER_BITS-1:0];
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    RX_LOW: begin
                        if (w_s) begin
                            r_high_cnt <= 4'd1;
                            r_state    <= RX_HIGH;
                        end else if (r_low_cnt == LOW_LAST) begin
                            r_frame_done   <= 1'b1;
                            r_frame_pixels <= r_pix_cnt;
                            if (r_bit_cnt != 5'd0) begin
                                r_err_partial <= 1'b1;
                            end else begin
                                r_err_partial <= r_err_partial & ~bus.i_err_clear;
                            end
                            r_pix_cnt <= '0;
                            r_bit_cnt <= 5'd0;
                            r_shift   <= 24'd0;
                            r_low_cnt <= 10'd0;
                            r_state   <= RX_IDLE;
                        end else begin
                            r_low_cnt <= r_low_cnt + 10'd1;
                        end
                    end
                    default: begin
                        r_state <= RX_SYNC;
                    end
                endcase
            end
        end
    end

    assign bus.o_pixel_data    = r_pixel_data;
    assign bus.o_pixel_index   = r_pixel_index;
    assign bus.o_pixel_valid   = r_pixel_valid;
    assign bus.o_frame_done    = r_frame_done;
    assign bus.o_frame_pixels  = r_frame_pixels;
    assign bus.o_err_partial   = r_err_partial;
    assign bus.o_err_long_high = r_err_long_high;
    assign bus.o_err_overrun   = r_err_overrun;
endmodule

// File: tb/tb_anton_neopixel_stream_decoder.sv
// Scoreboard bench for the NeoPixel stream decoder.
`timescale 1ns/1ps
module tb_anton_neopixel_stream_decoder;
    import anton_neopixel_stream_decoder_pkg::*;

    localparam int BE = 3;
    localparam int RD = 500;
    localparam int BB = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    anton_neopixel_stream_decoder_if #(.BUFFER_BITS(BB)) bus();

    anton_neopixel_stream_decoder #(
        .BUFFER_END    (BE),
        .RESET_DELAY   (RD),
        .BIT_THRESHOLD (4),
        .MAX_HIGH      (7)
    ) dut (
        .i_clk7mhz (clk),
        .i_rst     (rst),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int m_pix    = 0;
    logic [BB+23:0] pix_q[$];
    int             frame_q[$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int h, input int l);
        bus.i_stream_in = 1'b1;
        tick(h);
        bus.i_stream_in = 1'b0;
        tick(l);
    endtask

    // One pixel; h1/h0 are the high widths used for 1 and 0 bits.
    task automatic send_pixel_w(input logic [23:0] d, input int h1, input int h0);
        if (m_pix <= BE) begin
            pix_q.push_back({m_pix[BB-1:0], d});
        end
        if (m_pix <= BE) m_pix++;
        for (int i = 23; i >= 0; i--) begin
            if (d[i]) pulse(h1, 8 - h1);
            else      pulse(h0, 8 - h0);
        end
    endtask

    task automatic send_bits(input logic [23:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            if (d[23-i]) pulse(5, 3);
            else         pulse(2, 6);
        end
    endtask

    task automatic gap();
        bus.i_stream_in = 1'b0;
        frame_q.push_back(m_pix);
        m_pix = 0;
        tick(RD + 10);
    endtask

    task automatic clear_errors();
        bus.i_err_clear = 1'b1;
        tick(1);
        bus.i_err_clear = 1'b0;
    endtask

    // Output monitor: pops scoreboard entries on each strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_pixel_valid) begin
                if (pix_q.size() == 0) begin
                    check_eq("pixel_unexpected", 64'(pix_q.size()), 64'd1);
                end else begin
                    logic [BB+23:0] e;
                    e = pix_q.pop_front();
                    check_eq("pixel_data", 64'(bus.o_pixel_data), 64'(e[23:0]));
                    check_eq("pixel_index", 64'(bus.o_pixel_index), 64'(e[BB+23:24]));
                end
            end
            if (bus.o_frame_done) begin
                if (frame_q.size() == 0) begin
                    check_eq("frame_unexpected", 64'(frame_q.size()), 64'd1);
                end else begin
                    int f;
                    f = frame_q.pop_front();
                    check_eq("frame_pixels", 64'(bus.o_frame_pixels), 64'(f));
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [23:0] rnd;
        rst = 1'b1;
        bus.i_enable    = 1'b0;
        bus.i_err_clear = 1'b0;
        bus.i_stream_in = 1'b0;
        tick(3);
        check_eq("rst_pixel_data", 64'(bus.o_pixel_data), 64'd0);
        check_eq("rst_pixel_valid", 64'(bus.o_pixel_valid), 64'd0);
        check_eq("rst_frame_done", 64'(bus.o_frame_done), 64'd0);
        check_eq("rst_frame_pixels", 64'(bus.o_frame_pixels), 64'd0);
        check_eq("rst_errors", 64'({bus.o_err_partial, bus.o_err_long_high, bus.o_err_overrun}), 64'd0);
        check_eq("rst_state", 64'(dut.r_state), 64'(RX_SYNC));
        rst = 1'b0;
        bus.i_enable = 1'b1;

        // Low line for the reset gap reaches IDLE without a frame_done.
        tick(RD + 10);
        check_eq("sync_to_idle", 64'(dut.r_state), 64'(RX_IDLE));

        // Nominal pixel.
        send_pixel_w(24'hA5C3F0, 5, 2);
        gap();

        // Width boundaries: 3->0, 4->1, then 1->0, 7->1.
        send_pixel_w(24'h00FF0F, 4, 3);
        send_pixel_w(24'h123456, 7, 1);
        gap();
        check_eq("no_long_high_at_7", 64'(bus.o_err_long_high), 64'd0);
        pulse(8, 4);
        check_eq("long_high_set", 64'(bus.o_err_long_high), 64'd1);
        check_eq("long_high_sync", 64'(dut.r_state), 64'(RX_SYNC));
        tick(RD + 10);
        check_eq("long_high_resync", 64'(dut.r_state), 64'(RX_IDLE));
        clear_errors();
        check_eq("long_high_clear", 64'(bus.o_err_long_high), 64'd0);

        // Partial frame of 10 bits.
        send_bits(24'hB3C000, 10);
        gap();
        check_eq("partial_set", 64'(bus.o_err_partial), 64'd1);
        check_eq("partial_frame_pixels", 64'(bus.o_frame_pixels), 64'd0);
        clear_errors();
        check_eq("partial_clear", 64'(bus.o_err_partial), 64'd0);

        // Overrun: five pixels into a four-entry buffer.
        check_eq("overrun_idle", 64'(bus.o_err_overrun), 64'd0);
        for (int p = 0; p < 5; p++) send_pixel_w(24'h111111 * (p + 1), 5, 2);
        gap();
        check_eq("overrun_set", 64'(bus.o_err_overrun), 64'd1);
        check_eq("overrun_frame_pixels", 64'(bus.o_frame_pixels), 64'd4);
        clear_errors();

        // Loopback-style random frame.
        for (int p = 0; p < 3; p++) begin
            rnd = 24'($urandom);
            send_pixel_w(rnd, 5, 2);
        end
        gap();

        // enable drop mid-pixel discards data without error.
        send_bits(24'hFFF000, 12);
        bus.i_enable = 1'b0;
        tick(2);
        bus.i_enable = 1'b1;
        tick(RD + 10);
        check_eq("enable_drop_no_err", 64'({bus.o_err_partial, bus.o_err_long_high, bus.o_err_overrun}), 64'd0);
        check_eq("enable_drop_idle", 64'(dut.r_state), 64'(RX_IDLE));

        // Reset mid-pixel, then a clean frame.
        send_bits(24'hAAAAAA, 12);
        rst = 1'b1;
        bus.i_stream_in = 1'b0;
        tick(2);
        check_eq("midrst_pixel_data", 64'(bus.o_pixel_data), 64'd0);
        check_eq("midrst_frame_pixels", 64'(bus.o_frame_pixels), 64'd0);
        check_eq("midrst_state", 64'(dut.r_state), 64'(RX_SYNC));
        rst = 1'b0;
        m_pix = 0;
        tick(RD + 10);
        for (int p = 0; p < 2; p++) begin
            rnd = 24'($urandom);
            send_pixel_w(rnd, 5, 2);
        end
        gap();

        check_eq("pixels_outstanding", 64'(pix_q.size()), 64'd0);
        check_eq("frames_outstanding", 64'(frame_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
